// File: rtl/reaction_game_ctrl_pkg.sv
// reaction_pkg: shared definitions for the reaction-time game controller.
//   - state_e        : FSM state codes (IDLE=0 .. DONE=6)
//   - DEF_*          : default parameter values for reaction_game_ctrl
//   - GAP_TICKS      : inter-round pause length in game ticks
//   - LFSR_*         : LFSR reset/zero-seed substitute value and tap mask
//   - lfsr_step()    : one step of the 16-bit Fibonacci LFSR
package reaction_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARM       = 3'd1,
    ST_WAIT      = 3'd2,
    ST_GO        = 3'd3,
    ST_ROUND_END = 3'd4,
    ST_GAP       = 3'd5,
    ST_DONE      = 3'd6
  } state_e;

  localparam int          DEF_N_PLAYERS    = 2;
  localparam int          DEF_ROUNDS       = 5;
  localparam int          DEF_TICK_DIV     = 1000000;
  localparam int          DEF_MIN_DELAY    = 100;
  localparam logic [15:0] DEF_DELAY_MASK   = 16'h01FF;
  localparam int          DEF_TIMEOUT      = 300;
  localparam int          DEF_RT_W         = 9;
  localparam int          DEF_TOT_W        = 12;
  localparam int          DEF_FOUL_PENALTY = 300;

  localparam int          GAP_TICKS = 100;

  // Reset value, and the value used when a zero seed is supplied
  // (an all-zero Fibonacci LFSR would lock up).
  localparam logic [15:0] LFSR_RESET = 16'hACE1;
  // Taps 16,15,13,4 -> bits 15,14,12,3.
  localparam logic [15:0] LFSR_TAPS  = 16'hD008;

  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    return {q[14:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/reaction_game_ctrl_if.sv
// reaction_game_ctrl_if: game-side bus of the reaction-time controller.
//   Inputs to the controller : start, abort, seed[15:0], btn[N_PLAYERS]
//   Outputs from controller  : state[2:0], active, round_idx[3:0],
//                              rt[N_PLAYERS*RT_W], foul[N_PLAYERS],
//                              total[N_PLAYERS*TOT_W], round_done, game_done
//   master = button/screen side, slave = controller.
interface reaction_game_ctrl_if #(
  parameter int N_PLAYERS = 2,
  parameter int RT_W      = 9,
  parameter int TOT_W     = 12
);
  logic                        start;
  logic                        abort;
  logic [15:0]                 seed;
  logic [N_PLAYERS-1:0]        btn;
  logic [2:0]                  state;
  logic                        active;
  logic [3:0]                  round_idx;
  logic [N_PLAYERS*RT_W-1:0]   rt;
  logic [N_PLAYERS-1:0]        foul;
  logic [N_PLAYERS*TOT_W-1:0]  total;
  logic                        round_done;
  logic                        game_done;

  modport master (
    output start, abort, seed, btn,
    input  state, active, round_idx, rt, foul, total, round_done, game_done
  );

  modport slave (
    input  start, abort, seed, btn,
    output state, active, round_idx, rt, foul, total, round_done, game_done
  );
endinterface

// File: rtl/reaction_game_ctrl_lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR (taps 16,15,13,4) used for the random wait.
//   clk, rst : clock, asynchronous active-high reset (to LFSR_RESET)
//   load     : load seed (zero seed replaced by LFSR_RESET); wins over en
//   seed     : value to load
//   en       : advance one step
//   out      : current LFSR state
module lfsr16
  import reaction_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        en,
  output logic [15:0] out
);
  logic [15:0] lfsr_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       lfsr_reg <= LFSR_RESET;
    else if (load) lfsr_reg <= (seed == 16'h0000) ? LFSR_RESET : seed;
    else if (en)   lfsr_reg <= lfsr_step(lfsr_reg);
  end

  assign out = lfsr_reg;
endmodule

// File: rtl/reaction_game_ctrl.sv
// reaction_game_ctrl: multi-player, multi-round reaction-time game FSM.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : reaction_game_ctrl_if slave (start/abort/seed/btn in;
//              state/active/round_idx/rt/foul/total/round_done/game_done out)
// Each round: ARM picks a random wait, WAIT flags false starts, GO times
// each player's first press, ROUND_END adds the round cost (saturating) to
// every player's total, GAP pauses before re-arming. All counters run off a
// single-cycle tick strobe from a prescaler that is realigned in ARM.
module reaction_game_ctrl
  import reaction_pkg::*;
#(
  parameter int          N_PLAYERS    = DEF_N_PLAYERS,
  parameter int          ROUNDS       = DEF_ROUNDS,
  parameter int          TICK_DIV     = DEF_TICK_DIV,
  parameter int          MIN_DELAY    = DEF_MIN_DELAY,
  parameter logic [15:0] DELAY_MASK   = DEF_DELAY_MASK,
  parameter int          TIMEOUT      = DEF_TIMEOUT,
  parameter int          RT_W         = DEF_RT_W,
  parameter int          TOT_W        = DEF_TOT_W,
  parameter int          FOUL_PENALTY = DEF_FOUL_PENALTY
) (
  input  logic                 clk,
  input  logic                 rst,
  reaction_game_ctrl_if.slave  bus
);
  localparam logic [2:0] S_IDLE      = ST_IDLE;
  localparam logic [2:0] S_ARM       = ST_ARM;
  localparam logic [2:0] S_WAIT      = ST_WAIT;
  localparam logic [2:0] S_GO        = ST_GO;
  localparam logic [2:0] S_ROUND_END = ST_ROUND_END;
  localparam logic [2:0] S_GAP       = ST_GAP;
  localparam logic [2:0] S_DONE      = ST_DONE;

  localparam int             PW      = $clog2(TICK_DIV);
  localparam logic [TOT_W-1:0] TOT_MAX = {TOT_W{1'b1}};

  logic [2:0]              state_reg;
  logic [3:0]              round_idx_reg;
  logic [PW-1:0]           presc_reg;
  logic [15:0]             delay_cnt_reg;
  logic [RT_W-1:0]         rt_cnt_reg;
  logic [N_PLAYERS-1:0]    btn_q_reg;
  logic                    start_q_reg;
  logic                    round_done_reg;
  logic                    game_done_reg;

  logic                    tick;
  logic                    start_edge;
  logic                    rt_full;
  logic                    all_in;
  logic [N_PLAYERS-1:0]    press;
  logic [N_PLAYERS-1:0]    foul_vec;
  logic [N_PLAYERS-1:0]    pressed_vec;
  logic [N_PLAYERS*RT_W-1:0]  rt_bus;
  logic [N_PLAYERS*TOT_W-1:0] tot_bus;
  logic [15:0]             lfsr_out;

  assign tick       = (presc_reg == PW'(TICK_DIV - 1));
  assign start_edge = bus.start & ~start_q_reg;
  assign press      = bus.btn & ~btn_q_reg;
  assign rt_full    = (rt_cnt_reg == RT_W'(TIMEOUT));
  // A press arriving this cycle already counts, so GO can close on the
  // cycle after the last outstanding player presses.
  assign all_in     = &(foul_vec | pressed_vec | press);

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (!bus.abort && start_edge && (state_reg == S_IDLE || state_reg == S_DONE)),
    .seed (bus.seed),
    .en   (state_reg != S_IDLE),
    .out  (lfsr_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      round_idx_reg  <= '0;
      presc_reg      <= '0;
      delay_cnt_reg  <= '0;
      rt_cnt_reg     <= '0;
      btn_q_reg      <= '0;
      start_q_reg    <= 1'b0;
      round_done_reg <= 1'b0;
      game_done_reg  <= 1'b0;
    end else begin
      btn_q_reg      <= bus.btn;
      start_q_reg    <= bus.start;
      round_done_reg <= 1'b0;
      game_done_reg  <= 1'b0;
      presc_reg      <= (state_reg == S_ARM || tick) ? '0 : presc_reg + 1'b1;

      if (bus.abort) begin
        state_reg <= S_IDLE;
      end else begin
        case (state_reg)
          S_IDLE, S_DONE: begin
            if (start_edge) begin
              round_idx_reg <= '0;
              state_reg     <= S_ARM;
            end
          end
          S_ARM: begin
            delay_cnt_reg <= 16'(MIN_DELAY) + (lfsr_out & DELAY_MASK);
            state_reg     <= S_WAIT;
          end
          S_WAIT: begin
            if (delay_cnt_reg == '0) begin
              rt_cnt_reg <= '0;
              state_reg  <= S_GO;
            end else if (tick) begin
              delay_cnt_reg <= delay_cnt_reg - 1'b1;
            end
          end
          S_GO: begin
            if (tick && !rt_full) rt_cnt_reg <= rt_cnt_reg + 1'b1;
            if (all_in || rt_full) begin
              round_done_reg <= 1'b1;
              state_reg      <= S_ROUND_END;
            end
          end
          S_ROUND_END: begin
            if (round_idx_reg == 4'(ROUNDS - 1)) begin
              game_done_reg <= 1'b1;
              state_reg     <= S_DONE;
            end else begin
              round_idx_reg <= round_idx_reg + 1'b1;
              delay_cnt_reg <= 16'(GAP_TICKS);
              state_reg     <= S_GAP;
            end
          end
          S_GAP: begin
            if (delay_cnt_reg == '0)  state_reg     <= S_ARM;
            else if (tick)            delay_cnt_reg <= delay_cnt_reg - 1'b1;
          end
          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_PLAYERS; gi++) begin : g_player
      logic [RT_W-1:0]  rt_reg;
      logic [TOT_W-1:0] tot_reg;
      logic             foul_reg;
      logic             pressed_reg;
      logic [31:0]      add;
      logic [31:0]      sum;
      logic [TOT_W-1:0] tot_next;

      // Round cost: fixed penalty for a false start, full window when
      // nobody pressed, otherwise the measured reaction time.
      always_comb begin
        if (foul_reg)          add = 32'(FOUL_PENALTY);
        else if (!pressed_reg) add = 32'(TIMEOUT);
        else                   add = 32'(rt_reg);
        sum      = 32'(tot_reg) + add;
        tot_next = (sum > 32'(TOT_MAX)) ? TOT_MAX : sum[TOT_W-1:0];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rt_reg      <= '0;
          tot_reg     <= '0;
          foul_reg    <= 1'b0;
          pressed_reg <= 1'b0;
        end else if (!bus.abort) begin
          case (state_reg)
            S_IDLE, S_DONE: if (start_edge) tot_reg <= '0;
            S_ARM: begin
              rt_reg      <= '0;
              foul_reg    <= 1'b0;
              pressed_reg <= 1'b0;
            end
            S_WAIT: if (press[gi]) foul_reg <= 1'b1;
            S_GO: begin
              if (press[gi] && !foul_reg && !pressed_reg) begin
                rt_reg      <= rt_cnt_reg;
                pressed_reg <= 1'b1;
              end
            end
            S_ROUND_END: begin
              tot_reg <= tot_next;
              if (!foul_reg && !pressed_reg) rt_reg <= RT_W'(TIMEOUT);
            end
            default: ;
          endcase
        end
      end

      assign foul_vec[gi]                  = foul_reg;
      assign pressed_vec[gi]               = pressed_reg;
      assign rt_bus[gi*RT_W +: RT_W]       = rt_reg;
      assign tot_bus[gi*TOT_W +: TOT_W]    = tot_reg;
    end
  endgenerate

  assign bus.state      = state_reg;
  assign bus.active     = (state_reg == S_GO);
  assign bus.round_idx  = round_idx_reg;
  assign bus.rt         = rt_bus;
  assign bus.foul       = foul_vec;
  assign bus.total      = tot_bus;
  assign bus.round_done = round_done_reg;
  assign bus.game_done  = game_done_reg;
endmodule
